// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder
// Description : Instruction memory with a valid/ready request/response
//               handshake. It holds one outstanding fetch and answers after a
//               fixed LATENCY. Alignment and range errors return a NOP. A
//               program-load port can write the storage in any FSM state.
// Ports       : clock, reset                   - clock, synchronous active-high reset
//               addressToInstructionMemory,
//               req_valid / req_ready          - fetch request channel
//               instruction, misaligned,
//               out_of_range,
//               resp_valid / resp_ready        - fetch response channel
//               load_en, load_addr, load_data  - program-load write port
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addressToInstructionMemory,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [31:0] instruction,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        misaligned,
    output logic        out_of_range,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_mem [DEPTH];

    logic [31:0] w_rd_addr;
    logic [IDX_W-1:0] w_rd_idx;
    logic        w_rd_misaligned;
    logic        w_rd_oor;
    logic        w_enter_resp;

    logic [IDX_W-1:0] w_ld_idx;
    logic        w_ld_ok;

    // With LATENCY==1 the FSM enters RESP on the accept edge itself. The
    // captured register is not yet loaded then, so the live request address
    // is used for the read.
    assign w_rd_addr       = (r_state == S_IDLE) ? addressToInstructionMemory : r_addr;
    assign w_rd_idx        = w_rd_addr[IDX_W+1:2];
    assign w_rd_misaligned = |w_rd_addr[1:0];
    assign w_rd_oor        = |w_rd_addr[31:IDX_W+2];
    assign w_enter_resp    = (r_state != S_RESP) && (w_next_state == S_RESP);

    assign w_ld_idx = load_addr[IDX_W+1:2];
    assign w_ld_ok  = (load_addr[1:0] == 2'b00) && !(|load_addr[31:IDX_W+2]);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
    end

    // Request capture, latency counter and registered response
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_addr       <= 32'd0;
            instruction  <= 32'd0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_addr <= addressToInstructionMemory;
                r_cnt  <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Non-blocking read of r_mem gives read-before-write against a
            // load landing on the same edge.
            if (w_enter_resp) begin
                misaligned   <= w_rd_misaligned;
                out_of_range <= w_rd_oor;
                instruction  <= (w_rd_misaligned || w_rd_oor) ? 32'd0 : r_mem[w_rd_idx];
            end
        end
    end

    // Program storage: written by the load port, never cleared by reset
    always_ff @(posedge clock) begin
        if (!reset && load_en && w_ld_ok) begin
            r_mem[w_ld_idx] <= load_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_responder
// Description : Self-checking bench for instr_mem_responder. One instance uses
//               LATENCY=2 and the other LATENCY=1. Expected values come from a
//               word-array model of the program store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_responder;

    localparam int DEPTH = 64;

    logic clock = 1'b0;
    logic reset;

    // LATENCY=2 instance
    logic [31:0] addr0, instr0, load_addr0, load_data0;
    logic        req_valid0, req_ready0, resp_valid0, resp_ready0;
    logic        mis0, oor0, load_en0;

    // LATENCY=1 instance
    logic [31:0] addr1, instr1, load_addr1, load_data1;
    logic        req_valid1, req_ready1, resp_valid1, resp_ready1;
    logic        mis1, oor1, load_en1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clock = ~clock;

    instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .addressToInstructionMemory(addr0),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .instruction(instr0), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .misaligned(mis0), .out_of_range(oor0),
        .load_en(load_en0), .load_addr(load_addr0), .load_data(load_data0)
    );

    instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .addressToInstructionMemory(addr1),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .instruction(instr1), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .misaligned(mis1), .out_of_range(oor1),
        .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1)
    );

    // ---------------- reference model ----------------
    function automatic logic is_mis(input logic [31:0] a);
        return (a % 4) != 0;
    endfunction

    function automatic logic is_oor(input logic [31:0] a);
        return a >= 32'(DEPTH * 4);
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        if (is_mis(a) || is_oor(a)) return 32'd0;
        return model_mem[a / 4];
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom % 4)
            0, 1:    return 32'($urandom_range(0, DEPTH - 1) * 4);
            2:       return 32'($urandom_range(0, DEPTH * 4 - 1));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load0(input logic [31:0] a, input logic [31:0] d);
        load_en0 = 1'b1; load_addr0 = a; load_data0 = d;
        step();
        load_en0 = 1'b0;
        if (!is_mis(a) && !is_oor(a)) model_mem[a / 4] = d;
    endtask

    task automatic fetch0(input logic [31:0] a, input int hold, output int lat,
                          output logic [31:0] ins, output logic mis, output logic oor);
        addr0 = a; req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        addr0 = $urandom;
        lat = 0;
        while (resp_valid0 !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        ins = instr0; mis = mis0; oor = oor0;
        repeat (hold) step();
        resp_ready0 = 1'b1;
        step();
        resp_ready0 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++; if (req_ready0 !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready0 got %b exp 1", req_ready0); end
        n_checks++; if (resp_valid0 !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid0 got %b exp 0", resp_valid0); end
        n_checks++; if (instr0 !== 32'd0) begin n_errors++; $display("FAIL reset_instr0 got %h exp 0", instr0); end
        n_checks++; if ({mis0, oor0} !== 2'b00) begin n_errors++; $display("FAIL reset_flags0 got %b exp 00", {mis0, oor0}); end
        n_checks++; if (req_ready1 !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready1 got %b exp 1", req_ready1); end
        n_checks++; if (resp_valid1 !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid1 got %b exp 0", resp_valid1); end
        n_checks++; if (instr1 !== 32'd0) begin n_errors++; $display("FAIL reset_instr1 got %h exp 0", instr1); end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] ins; logic mis, oor;
        load0(32'h10, 32'h2002000A);
        fetch0(32'h10, 0, lat, ins, mis, oor);
        n_checks++; if (lat != 2) begin n_errors++; $display("FAIL basic_latency got %0d exp 2", lat); end
        n_checks++; if (ins !== 32'h2002000A) begin n_errors++; $display("FAIL basic_instr got %h exp 2002000a", ins); end
        n_checks++; if ({mis, oor} !== 2'b00) begin n_errors++; $display("FAIL basic_flags got %b exp 00", {mis, oor}); end
    endtask

    task automatic test_errors();
        logic [31:0] tbl [5] = '{32'h12, 32'h100, 32'h102, 32'h3, 32'hFFFF_FFFC};
        int lat; logic [31:0] ins; logic mis, oor;
        for (int i = 0; i < 5; i++) begin
            fetch0(tbl[i], 1, lat, ins, mis, oor);
            n_checks++; if (lat != 2) begin n_errors++; $display("FAIL err_latency addr %h got %0d exp 2", tbl[i], lat); end
            n_checks++; if (ins !== 32'd0) begin n_errors++; $display("FAIL err_instr addr %h got %h exp 0", tbl[i], ins); end
            n_checks++; if ({mis, oor} !== {is_mis(tbl[i]), is_oor(tbl[i])}) begin
                n_errors++; $display("FAIL err_flags addr %h got %b exp %b", tbl[i], {mis, oor}, {is_mis(tbl[i]), is_oor(tbl[i])});
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a = 32'h40;
        logic [31:0] e;
        int wait_cnt = 0;
        int extra = 0;
        e = exp_instr(a);
        addr0 = a; req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        while (resp_valid0 !== 1'b1 && wait_cnt < 40) begin step(); wait_cnt++; end
        for (int i = 0; i < 5; i++) begin
            addr0 = $urandom; req_valid0 = 1'($urandom % 2);
            step();
            n_checks++; if (resp_valid0 !== 1'b1 || req_ready0 !== 1'b0 || instr0 !== e) begin
                n_errors++; $display("FAIL stall_hold cyc %0d valid %b ready %b instr %h exp 1 0 %h", i, resp_valid0, req_ready0, instr0, e);
            end
        end
        req_valid0 = 1'b0; resp_ready0 = 1'b1;
        step();
        resp_ready0 = 1'b0;
        n_checks++; if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
            n_errors++; $display("FAIL stall_release valid %b ready %b exp 0 1", resp_valid0, req_ready0);
        end
        n_checks++; if (instr0 !== e) begin n_errors++; $display("FAIL stall_after_hold got %h exp %h", instr0, e); end
        repeat (4) begin step(); if (resp_valid0 !== 1'b0) extra++; end
        n_checks++; if (extra != 0) begin n_errors++; $display("FAIL stall_single_resp extra cycles %0d exp 0", extra); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] a = 32'h24;
        logic [31:0] e;
        int spurious = 0;
        int lat; logic [31:0] ins; logic mis, oor;
        e = exp_instr(a);
        addr0 = a; req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        // In WAIT now: reset together with a load that must be dropped
        reset = 1'b1; load_en0 = 1'b1; load_addr0 = a; load_data0 = ~e;
        step();
        reset = 1'b0; load_en0 = 1'b0;
        n_checks++; if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
            n_errors++; $display("FAIL abort_state valid %b ready %b exp 0 1", resp_valid0, req_ready0);
        end
        repeat (4) begin step(); if (resp_valid0 !== 1'b0) spurious++; end
        n_checks++; if (spurious != 0) begin n_errors++; $display("FAIL abort_no_resp got %0d exp 0", spurious); end
        fetch0(a, 0, lat, ins, mis, oor);
        n_checks++; if (ins !== e) begin n_errors++; $display("FAIL abort_mem_kept got %h exp %h", ins, e); end
    endtask

    task automatic test_load_hazard();
        logic [31:0] a = 32'h20;
        int lat; logic [31:0] ins; logic mis, oor;
        // Load during WAIT to the pending word is seen by the response
        addr0 = a; req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        load_en0 = 1'b1; load_addr0 = a; load_data0 = 32'hAAAA0000;
        step();
        load_en0 = 1'b0; model_mem[a / 4] = 32'hAAAA0000;
        step();
        n_checks++; if (resp_valid0 !== 1'b1 || instr0 !== 32'hAAAA0000) begin
            n_errors++; $display("FAIL hazard_wait_load valid %b instr %h exp 1 aaaa0000", resp_valid0, instr0);
        end
        resp_ready0 = 1'b1; step(); resp_ready0 = 1'b0;
        // Load on the RESP-entry edge: read returns the old word
        addr0 = a; req_valid0 = 1'b1;
        step();
        req_valid0 = 1'b0;
        step();
        load_en0 = 1'b1; load_addr0 = a; load_data0 = 32'hBBBB0000;
        step();
        load_en0 = 1'b0;
        n_checks++; if (resp_valid0 !== 1'b1 || instr0 !== 32'hAAAA0000) begin
            n_errors++; $display("FAIL hazard_rbw valid %b instr %h exp 1 aaaa0000", resp_valid0, instr0);
        end
        model_mem[a / 4] = 32'hBBBB0000;
        resp_ready0 = 1'b1; step(); resp_ready0 = 1'b0;
        fetch0(a, 0, lat, ins, mis, oor);
        n_checks++; if (ins !== 32'hBBBB0000) begin n_errors++; $display("FAIL hazard_next got %h exp bbbb0000", ins); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] ins; logic mis, oor;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            if ($urandom % 2 == 1) load0(rand_addr(), $urandom);
            a = rand_addr();
            fetch0(a, int'($urandom % 3), lat, ins, mis, oor);
            n_checks++; if (lat != 2) begin n_errors++; $display("FAIL rand_latency addr %h got %0d exp 2", a, lat); end
            n_checks++; if (ins !== exp_instr(a)) begin n_errors++; $display("FAIL rand_instr addr %h got %h exp %h", a, ins, exp_instr(a)); end
            n_checks++; if (mis !== is_mis(a)) begin n_errors++; $display("FAIL rand_mis addr %h got %b exp %b", a, mis, is_mis(a)); end
            n_checks++; if (oor !== is_oor(a)) begin n_errors++; $display("FAIL rand_oor addr %h got %b exp %b", a, oor, is_oor(a)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [3];
        int k = 0;
        int last = -1;
        for (int i = 0; i < 3; i++) begin
            v[i] = $urandom;
            load_en1 = 1'b1; load_addr1 = 32'(i * 4); load_data1 = v[i];
            step();
        end
        load_en1 = 1'b0;
        resp_ready1 = 1'b1;
        addr1 = 32'd0; req_valid1 = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            if (resp_valid1 === 1'b1) begin
                if (k < 3) begin
                    n_checks++; if (instr1 !== v[k]) begin n_errors++; $display("FAIL b2b_instr idx %0d got %h exp %h", k, instr1, v[k]); end
                end
                if (k > 0) begin
                    n_checks++; if (cyc - last != 2) begin n_errors++; $display("FAIL b2b_spacing idx %0d got %0d exp 2", k, cyc - last); end
                end
                last = cyc;
                k++;
                addr1 = 32'(k * 4);
                if (k >= 3) req_valid1 = 1'b0;
            end
        end
        n_checks++; if (k != 3) begin n_errors++; $display("FAIL b2b_count got %0d exp 3", k); end
        resp_ready1 = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        addr0 = '0; req_valid0 = 1'b0; resp_ready0 = 1'b0;
        load_en0 = 1'b0; load_addr0 = '0; load_data0 = '0;
        addr1 = '0; req_valid1 = 1'b0; resp_ready1 = 1'b0;
        load_en1 = 1'b0; load_addr1 = '0; load_data1 = '0;
        test_reset();
        for (int i = 0; i < DEPTH; i++) load0(32'(i * 4), $urandom);
        test_basic();
        test_errors();
        test_stall();
        test_reset_abort();
        test_load_hazard();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
